// File: rtl/quant_pkg.sv
// quant_pkg
// Shared constants and state encoding for the INT4 quantizer block controller.
//   ROWS   : rows per block (equals the quantizer pass length)
//   LANES  : lanes per row
//   DW     : lane width, Q30.10
//   ADDR_W : VSQ buffer address width
//   CNT_W  : completed-block counter width
package quant_pkg;

    localparam int unsigned ROWS   = 64;
    localparam int unsigned LANES  = 16;
    localparam int unsigned DW     = 40;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BUS_W  = LANES * DW;

    typedef enum logic [2:0] {
        FILL,
        PAD,
        WAIT,
        START,
        QUANT
    } state_e;

endpackage

// File: rtl/quant_sched_if.sv
// quant_sched_if
// Bundles the row input stream, VSQ buffer write port, quantizer hooks and
// the scale-factor output slot of quant_sched.
//   slave  : the controller (drives o_* signals)
//   master : the surrounding system / bench (drives i_* signals)
interface quant_sched_if;
    import quant_pkg::*;

    logic                i_in_valid;
    logic                o_in_ready;
    logic [BUS_W-1:0]    i_in_data;
    logic                i_in_last;
    logic                o_buf_we;
    logic [ADDR_W-1:0]   o_buf_waddr;
    logic [BUS_W-1:0]    o_buf_wdata;
    logic [BUS_W-1:0]    o_q_data;
    logic                o_q_start;
    logic [BUS_W-1:0]    i_q_sf_data;
    logic                o_sf_valid;
    logic [BUS_W-1:0]    o_sf_data;
    logic                i_sf_ready;
    logic                o_busy;
    logic [CNT_W-1:0]    o_blk_cnt;

    modport slave (
        input  i_in_valid, i_in_data, i_in_last, i_q_sf_data, i_sf_ready,
        output o_in_ready, o_buf_we, o_buf_waddr, o_buf_wdata, o_q_data,
               o_q_start, o_sf_valid, o_sf_data, o_busy, o_blk_cnt
    );

    modport master (
        output i_in_valid, i_in_data, i_in_last, i_q_sf_data, i_sf_ready,
        input  o_in_ready, o_buf_we, o_buf_waddr, o_buf_wdata, o_q_data,
               o_q_start, o_sf_valid, o_sf_data, o_busy, o_blk_cnt
    );

endinterface

// File: rtl/quant_sched.sv
// quant_sched
// Block controller for the per-block INT4 quantizer and its VSQ row buffer.
// Accepts 64 rows per block into the buffer (zero-padding short blocks),
// feeds accepted rows to the quantizer running-max path, pulses the
// quantizer start, times the 64-cycle pass and captures the scale factors
// into a single backpressured output slot.
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset (shared with the quantizer)
//   bus     : row stream, buffer write port, quantizer hooks, sf slot
module quant_sched
    import quant_pkg::*;
(
    input  logic          i_clk,
    input  logic          i_rst_n,
    quant_sched_if.slave  bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROWS - 1);

    state_e             state_q,    state_d;
    logic [ADDR_W-1:0]  wr_addr_q,  wr_addr_d;
    logic [ADDR_W-1:0]  qcnt_q,     qcnt_d;
    logic               sf_valid_q, sf_valid_d;
    logic [BUS_W-1:0]   sf_data_q,  sf_data_d;
    logic [CNT_W-1:0]   blk_cnt_q,  blk_cnt_d;

    logic               in_ready;
    logic               buf_we;
    logic [BUS_W-1:0]   row_out;
    logic               q_start;
    logic               slot_free;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= FILL;
            wr_addr_q  <= '0;
            qcnt_q     <= '0;
            sf_valid_q <= 1'b0;
            sf_data_q  <= '0;
            blk_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            qcnt_q     <= qcnt_d;
            sf_valid_q <= sf_valid_d;
            sf_data_q  <= sf_data_d;
            blk_cnt_q  <= blk_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        qcnt_d     = qcnt_q;
        sf_valid_d = sf_valid_q;
        sf_data_d  = sf_data_q;
        blk_cnt_d  = blk_cnt_q;
        in_ready   = 1'b0;
        buf_we     = 1'b0;
        row_out    = '0;
        q_start    = 1'b0;

        // A slot being drained this cycle counts as free, both for leaving
        // WAIT and for going straight to START at the end of a fill/pad.
        slot_free = !sf_valid_q || bus.i_sf_ready;

        if (sf_valid_q && bus.i_sf_ready) begin
            sf_valid_d = 1'b0;
        end

        unique case (state_q)
            FILL: begin
                in_ready = 1'b1;
                if (bus.i_in_valid) begin
                    buf_we    = 1'b1;
                    row_out   = bus.i_in_data;
                    wr_addr_d = wr_addr_q + ADDR_W'(1);
                    // A last flag on address 63 is simply a full block.
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d = slot_free ? START : WAIT;
                    end else if (bus.i_in_last) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                buf_we    = 1'b1;
                wr_addr_d = wr_addr_q + ADDR_W'(1);
                if (wr_addr_q == LAST_ADDR) begin
                    state_d = slot_free ? START : WAIT;
                end
            end
            WAIT: begin
                if (slot_free) begin
                    state_d = START;
                end
            end
            START: begin
                q_start = 1'b1;
                qcnt_d  = '0;
                state_d = QUANT;
            end
            QUANT: begin
                qcnt_d = qcnt_q + ADDR_W'(1);
                // The quantizer clears its max on the edge it finishes, so
                // the scale factors must be taken in this final cycle.
                if (qcnt_q == LAST_ADDR) begin
                    sf_valid_d = 1'b1;
                    sf_data_d  = bus.i_q_sf_data;
                    blk_cnt_d  = blk_cnt_q + CNT_W'(1);
                    wr_addr_d  = '0;
                    state_d    = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    assign bus.o_in_ready  = in_ready;
    assign bus.o_buf_we    = buf_we;
    assign bus.o_buf_waddr = wr_addr_q;
    assign bus.o_buf_wdata = row_out;
    assign bus.o_q_data    = row_out;
    assign bus.o_q_start   = q_start;
    assign bus.o_sf_valid  = sf_valid_q;
    assign bus.o_sf_data   = sf_data_q;
    assign bus.o_blk_cnt   = blk_cnt_q;
    assign bus.o_busy      = !((state_q == FILL) && (wr_addr_q == '0));

endmodule

// File: tb/tb_quant_sched.sv
// tb_quant_sched
// Self-checking bench for quant_sched. A behavioural quantizer responder
// turns o_q_start/o_q_data into scale factors ((max|x|*36)>>8 per lane).
// A block-level reference model predicts every output each cycle, and a few
// hand-computed literals pin the model itself.
module tb_quant_sched;
    import quant_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    quant_sched_if bus();

    quant_sched dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(string name, logic [BUS_W-1:0] act, logic [BUS_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void timeout_fail(string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endfunction

    function automatic logic [DW-1:0] lane_of(logic [BUS_W-1:0] row, int unsigned l);
        return row[l*DW +: DW];
    endfunction

    function automatic longint abs_lane(logic [DW-1:0] x);
        logic signed [DW-1:0] s;
        longint v;
        s = x;
        v = longint'(s);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [DW-1:0] sf_of_max(longint m);
        return DW'((m * 36) >> 8);
    endfunction

    function automatic logic [BUS_W-1:0] rand_row();
        logic [BUS_W-1:0] r;
        r = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            int v;
            logic signed [DW-1:0] s;
            v = int'($urandom_range(0, 2097151)) - 1048576;
            s = v;
            r[l*DW +: DW] = s;
        end
        return r;
    endfunction

    // ---------------- quantizer responder ----------------
    longint qmax [LANES];
    int     qleft;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++) qmax[l] <= 0;
            qleft <= 0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (qleft == 1) qmax[l] <= 0;
                else if (abs_lane(lane_of(bus.o_q_data, l)) > qmax[l])
                    qmax[l] <= abs_lane(lane_of(bus.o_q_data, l));
            end
            if (bus.o_q_start) qleft <= ROWS;
            else if (qleft > 0) qleft <= qleft - 1;
        end
    end

    always_comb begin
        bus.i_q_sf_data = '0;
        for (int unsigned l = 0; l < LANES; l++)
            bus.i_q_sf_data[l*DW +: DW] = sf_of_max(qmax[l]);
    end

    // ---------------- reference model + per-cycle compare ----------------
    int               m_addr;
    bit               m_pad, m_wait, m_start, m_sfv;
    int               m_qleft;
    logic [BUS_W-1:0] m_sf;
    int               m_blk;
    longint           bmax [LANES];

    initial begin : cmp
        bit fill, acc, we, done, free;
        logic [BUS_W-1:0] row;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_addr = 0; m_pad = 0; m_wait = 0; m_start = 0; m_qleft = 0;
                m_sfv = 0; m_sf = '0; m_blk = 0;
                for (int l = 0; l < LANES; l++) bmax[l] = 0;
            end
            fill = !m_pad && !m_wait && !m_start && (m_qleft == 0);
            acc  = fill && bus.i_in_valid;
            we   = acc || m_pad;
            row  = acc ? bus.i_in_data : '0;

            chk("in_ready", bus.o_in_ready, fill);
            chk("buf_we", bus.o_buf_we, we);
            if (we) begin
                chk("buf_waddr", bus.o_buf_waddr, m_addr);
                chk("buf_wdata", bus.o_buf_wdata, row);
            end
            chk("q_data", bus.o_q_data, row);
            chk("q_start", bus.o_q_start, m_start);
            chk("sf_valid", bus.o_sf_valid, m_sfv);
            chk("sf_data", bus.o_sf_data, m_sf);
            chk("blk_cnt", bus.o_blk_cnt, m_blk);
            chk("busy", bus.o_busy, !(fill && m_addr == 0));

            if (rst_n) begin
                free = !m_sfv || bus.i_sf_ready;
                done = 0;
                if (m_sfv && bus.i_sf_ready) m_sfv = 0;
                if (acc) begin
                    for (int l = 0; l < LANES; l++)
                        if (abs_lane(lane_of(row, l)) > bmax[l]) bmax[l] = abs_lane(lane_of(row, l));
                    done = (m_addr == ROWS - 1);
                    if (!done && bus.i_in_last) m_pad = 1;
                    m_addr = (m_addr + 1) % ROWS;
                end else if (m_pad) begin
                    done = (m_addr == ROWS - 1);
                    m_addr = (m_addr + 1) % ROWS;
                end else if (m_wait) begin
                    if (free) begin m_wait = 0; m_start = 1; end
                end else if (m_start) begin
                    m_start = 0;
                    m_qleft = ROWS;
                end else if (m_qleft > 0) begin
                    if (m_qleft == 1) begin
                        m_sfv = 1;
                        for (int l = 0; l < LANES; l++) begin
                            m_sf[l*DW +: DW] = sf_of_max(bmax[l]);
                            bmax[l] = 0;
                        end
                        m_blk = (m_blk + 1) % 65536;
                        m_addr = 0;
                    end
                    m_qleft--;
                end
                if (done) begin
                    m_pad = 0;
                    if (free) m_start = 1; else m_wait = 1;
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [BUS_W-1:0] d, input bit last);
        int budget;
        budget = 300;
        bus.i_in_valid = 1'b1;
        bus.i_in_data  = d;
        bus.i_in_last  = last;
        @(negedge clk);
        while (!bus.o_in_ready && budget > 0) begin
            budget--;
            @(negedge clk);
        end
        if (budget == 0) timeout_fail("send_row");
        tick();
        bus.i_in_valid = 1'b0;
        bus.i_in_last  = 1'b0;
    endtask

    task automatic send_full_block();
        for (int i = 0; i < ROWS; i++) send_row(rand_row(), i == ROWS - 1);
    endtask

    // Called in the cycle after the last row was accepted (k = 1).
    task automatic observe(output int start_at, output int sf_at, output int starts,
                           output int pads, output logic [BUS_W-1:0] sf_seen,
                           output logic [CNT_W-1:0] blk_seen);
        start_at = -1; sf_at = -1; starts = 0; pads = 0; sf_seen = '0; blk_seen = '0;
        for (int k = 1; k <= 250; k++) begin
            @(negedge clk);
            if (bus.o_q_start) begin
                starts++;
                if (start_at < 0) start_at = k;
            end
            if (start_at < 0 && bus.o_buf_we && !bus.o_in_ready) pads++;
            if (bus.o_sf_valid && sf_at < 0 && start_at >= 0) begin
                sf_at = k;
                sf_seen = bus.o_sf_data;
                blk_seen = bus.o_blk_cnt;
            end
            tick();
            if (sf_at >= 0) break;
        end
        if (sf_at < 0) timeout_fail("observe_sf");
    endtask

    task automatic check_reset_outputs(string tag);
        @(negedge clk);
        chk({tag, "_in_ready"}, bus.o_in_ready, 1'b1);
        chk({tag, "_sf_valid"}, bus.o_sf_valid, 1'b0);
        chk({tag, "_sf_data"}, bus.o_sf_data, '0);
        chk({tag, "_q_start"}, bus.o_q_start, 1'b0);
        chk({tag, "_buf_we"}, bus.o_buf_we, 1'b0);
        chk({tag, "_q_data"}, bus.o_q_data, '0);
        chk({tag, "_blk_cnt"}, bus.o_blk_cnt, 16'd0);
        chk({tag, "_busy"}, bus.o_busy, 1'b0);
    endtask

    // ---------------- scenario ----------------
    initial begin : drive
        int st, sfa, ns, np, bad;
        logic [BUS_W-1:0] sfs, held, r;
        logic [CNT_W-1:0] blk;
        logic signed [DW-1:0] sv;

        bus.i_in_valid = 1'b0;
        bus.i_in_data  = '0;
        bus.i_in_last  = 1'b0;
        bus.i_sf_ready = 1'b1;
        rst_n = 1'b0;
        tick(); tick();
        check_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // Block 1: lane0 = 1..64, lane3 carries -2000 and +1500.
        for (int i = 0; i < ROWS; i++) begin
            r = '0;
            r[0 +: DW] = DW'(i + 1);
            if (i == 5)  begin sv = -2000; r[3*DW +: DW] = sv; end
            if (i == 40) begin sv = 1500;  r[3*DW +: DW] = sv; end
            send_row(r, i == ROWS - 1);
        end
        observe(st, sfa, ns, np, sfs, blk);
        chk("b1_start_delay", st, 1);
        chk("b1_start_count", ns, 1);
        chk("b1_sf_delay", sfa, 66);
        chk("b1_sf_lane0", lane_of(sfs, 0), 40'd9);
        chk("b1_sf_lane3", lane_of(sfs, 3), 40'd281);
        chk("b1_blk_cnt", blk, 16'd1);

        // Block 2: short block, last at row 10; lane1 = 100*(row+1).
        for (int i = 0; i <= 10; i++) begin
            r = rand_row();
            r[1*DW +: DW] = DW'(100 * (i + 1));
            send_row(r, i == 10);
        end
        observe(st, sfa, ns, np, sfs, blk);
        chk("b2_pad_cycles", np, 53);
        chk("b2_start_delay", st, 54);
        chk("b2_sf_delay", sfa, 119);
        chk("b2_sf_lane1", lane_of(sfs, 1), 40'd154);
        chk("b2_blk_cnt", blk, 16'd2);

        // Blocks 3 and 4 with the consumer stalled.
        bus.i_sf_ready = 1'b0;
        send_full_block();
        observe(st, sfa, ns, np, held, blk);
        chk("b3_sf_delay", sfa, 66);
        send_full_block();
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.o_q_start || bus.o_in_ready || bus.o_sf_data !== held) bad++;
            tick();
        end
        chk("wait_hold", bad, 0);
        chk("wait_busy", bus.o_busy, 1'b1);
        bus.i_sf_ready = 1'b1;
        tick();
        observe(st, sfa, ns, np, sfs, blk);
        chk("b4_start_after_free", st, 1);
        chk("b4_sf_delay", sfa, 66);
        chk("b4_blk_cnt", blk, 16'd4);

        // Random traffic with gaps, early lasts and consumer backpressure.
        for (int c = 0; c < 900; c++) begin
            bus.i_in_valid = ($urandom_range(0, 1) == 1);
            bus.i_in_last  = ($urandom_range(0, 19) == 0);
            bus.i_in_data  = rand_row();
            bus.i_sf_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        bus.i_in_valid = 1'b0;
        bus.i_in_last  = 1'b0;
        bus.i_sf_ready = 1'b1;
        send_row(rand_row(), 1'b1);
        bad = 1;
        for (int k = 0; k < 300 && bad != 0; k++) begin
            @(negedge clk);
            if (!bus.o_busy) bad = 0;
            tick();
        end
        if (bad != 0) timeout_fail("drain_idle");

        // Reset in the middle of a quant pass (qcnt == 30).
        send_full_block();
        @(negedge clk);
        chk("rst_pre_start", bus.o_q_start, 1'b1);
        for (int k = 0; k < 31; k++) tick();
        rst_n = 1'b0;
        check_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        send_full_block();
        observe(st, sfa, ns, np, sfs, blk);
        chk("post_rst_sf_delay", sfa, 66);
        chk("post_rst_blk_cnt", blk, 16'd1);

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
